// File: rtl/and16_gate_if.sv
// Operand/result bundle for the registered 16-bit AND unit.
// master drives operands, slave (the unit) drives the result and flags.
interface and16_gate_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zr;
    logic             ng;
    logic [CNT_W-1:0] popcnt;

    modport master (
        output in_valid, a, b,
        input  out, out_valid, zr, ng, popcnt
    );

    modport slave (
        input  in_valid, a, b,
        output out, out_valid, zr, ng, popcnt
    );
endinterface

// File: rtl/and16_gate.sv
// Registered 16-bit bitwise AND with Hack status flags and popcount.
// One result per accepted beat, one cycle of latency, no backpressure.
module and16_gate #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    and16_gate_if.slave  bus
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] and_w;
    logic [CNT_W-1:0] pc_w;

    assign and_w = bus.a & bus.b;

    // Count the ones of the AND result that would be captured.
    always_comb begin
        pc_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc_w = pc_w + CNT_W'(and_w[i]);
        end
    end

    // Next state: load a fresh result on a beat, otherwise hold the
    // result and flags; the select keeps idle-cycle X operands out.
    always_comb begin
        out_d = out_q;
        zr_d  = zr_q;
        ng_d  = ng_q;
        cnt_d = cnt_q;
        vld_d = 1'b0;
        if (bus.in_valid) begin
            out_d = and_w;
            zr_d  = (and_w == '0);
            ng_d  = and_w[WIDTH-1];
            cnt_d = pc_w;
            vld_d = 1'b1;
        end
    end

    // Result and flag registers, cleared asynchronously (zr reads 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
            zr_q  <= zr_d;
            ng_q  <= ng_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.popcnt    = cnt_q;
endmodule

// File: tb/tb_and16_gate.sv
// Bench for and16_gate: table-driven beats checked through a
// scoreboard queue, plus reset and idle-hold sequences.
module tb_and16_gate;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic        zr;
        logic        ng;
        logic [4:0]  pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_v = 1'b0;
    vec_t hold;
    vec_t sb[$];
    vec_t tbl[6];

    and16_gate_if #(.WIDTH(16), .CNT_W(5)) ifc ();

    and16_gate #(.WIDTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        v.a  = a;
        v.b  = b;
        v.o  = a & b;
        v.zr = ((a & b) == 16'h0);
        v.ng = a[15] & b[15];
        v.pc = 5'($countones(a & b));
        return v;
    endfunction

    function automatic vec_t zero_rec();
        vec_t v;
        v.a  = '0;
        v.b  = '0;
        v.o  = '0;
        v.zr = 1'b0;
        v.ng = 1'b0;
        v.pc = '0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b1;
        ifc.a = v.a;
        ifc.b = v.b;
        sb.push_back(v);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.a = 'x;
        ifc.b = 'x;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"}, 32'(ifc.out), 32'h0);
        chk({tag, "_vld"}, 32'(ifc.out_valid), 32'h0);
        chk({tag, "_zr"}, 32'(ifc.zr), 32'h0);
        chk({tag, "_ng"}, 32'(ifc.ng), 32'h0);
        chk({tag, "_pc"}, 32'(ifc.popcnt), 32'h0);
    endtask

    // Bench-side capture model: a beat is expected after each edge
    // that saw in_valid with reset released.
    always @(posedge clk) begin
        exp_v = ifc.in_valid && rst_n;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_reset_vals("rst");
            hold = zero_rec();
        end else if (exp_v) begin
            chk("vld_hi", 32'(ifc.out_valid), 32'h1);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: got beat %0h want none", ifc.out);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("out", 32'(ifc.out), 32'(e.o));
                chk("zr", 32'(ifc.zr), 32'(e.zr));
                chk("ng", 32'(ifc.ng), 32'(e.ng));
                chk("popcnt", 32'(ifc.popcnt), 32'(e.pc));
                hold = e;
            end
        end else begin
            chk("vld_lo", 32'(ifc.out_valid), 32'h0);
            chk("hold_out", 32'(ifc.out), 32'(hold.o));
            chk("hold_zr", 32'(ifc.zr), 32'(hold.zr));
            chk("hold_ng", 32'(ifc.ng), 32'(hold.ng));
            chk("hold_pc", 32'(ifc.popcnt), 32'(hold.pc));
        end
    end

    initial begin
        hold = zero_rec();
        ifc.in_valid = 1'b0;
        ifc.a = '0;
        ifc.b = '0;

        tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'd0};
        tbl[1] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 5'd0};
        tbl[2] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'd0};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 5'd16};
        tbl[4] = '{16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b0, 5'd0};
        tbl[5] = '{16'h1234, 16'hABCD, 16'h0204, 1'b0, 1'b0, 5'd2};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Six back-to-back beats, then two idle cycles holding 0204.
        for (int i = 0; i < 6; i++) drive(tbl[i]);
        idle();
        idle();

        // Random beats with occasional bubbles.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            drive(mk(16'($urandom), 16'($urandom)));
        end
        idle();

        // Async reset while out holds FFFF.
        drive(tbl[3]);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        repeat (3) @(negedge clk);
        #1 chk_reset_vals("rst_held");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset landing between a capture and its report.
        drive(tbl[5]);
        @(posedge clk);
        #2 rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        sb.delete();
        #1 chk_reset_vals("midop_rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle();
        idle();

        // Recovery after reset.
        drive(mk(16'hF0F0, 16'hFF00));
        drive(mk(16'h8001, 16'h8003));
        idle();
        idle();
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
